pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL use one clock `clk`; `reset` SHALL be synchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  id_reg_rs1  in  5  rs1 index of instruction in ID
  id_reg_rs2  in  5  rs2 index of instruction in ID
  ex_reg_rd  in  5  rd index of instruction in EX
  ex_load_word_memory  in  1  instruction in EX is a load
  ex_redirect  in  1  taken branch or jump resolved in EX
  icache_miss  in  1  instruction cache miss this cycle
  icache_ready  in  1  instruction refill complete
  dcache_miss  in  1  data cache miss for instruction in MEM
  dcache_ready  in  1  data refill complete
  pc_hold  out  1  PC keeps its value
  ifid_hold  out  1  IF/ID register keeps its value
  ifid_flush  out  1  IF/ID register loads a NOP
  idex_bubble  out  1  drives the ID/EX register stall input (controls zeroed)
  idex_hold  out  1  ID/EX register fully frozen
  exmem_hold  out  1  EX/MEM register frozen
  memwb_hold  out  1  MEM/WB register frozen
  state  out  2  FSM state: 0 RUN, 1 IMISS, 2 DMISS
  stall_count  out  32  stall-cycle counter

Function
REQ-003 Load-use hazard (luh) SHALL be: ex_load_word_memory & ex_reg_rd != 0 & (ex_reg_rd == id_reg_rs1 | ex_reg_rd == id_reg_rs2).
REQ-004 State RUN, priority high to low: dcache_miss, ex_redirect, luh, icache_miss.
REQ-005 RUN + dcache_miss: all hold outputs (pc, ifid, idex, exmem, memwb) SHALL be 1 in the same cycle; next state DMISS.
REQ-006 DMISS: all hold outputs SHALL be 1 and other inputs SHALL be ignored; on dcache_ready, holds SHALL stay 1 that cycle, and the next state SHALL be RUN.
REQ-007 RUN + ex_redirect (no dcache_miss): ifid_flush=1, idex_bubble=1, pc_hold=0 (target loads); luh and icache_miss ignored that cycle; state stays RUN.
REQ-008 RUN + luh (no dcache_miss, no redirect): pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly that cycle; state stays RUN.
REQ-009 RUN + icache_miss (none of the above): pc_hold=1, ifid_flush=1; next state IMISS.
REQ-010 IMISS: pc_hold=1, ifid_flush=1 each cycle; ID/EX and later stages SHALL advance unless dcache_miss.
REQ-011 IMISS + dcache_miss: next state DMISS with all holds; a pending icache refill SHALL NOT be lost: an internal flag imiss_pending SHALL be set, and on leaving DMISS the next state SHALL be IMISS instead of RUN if icache_ready has not arrived.
REQ-012 IMISS + ex_redirect: pc_hold=0 that cycle (target loads); internal kill flag SHALL set; state stays IMISS.
REQ-013 IMISS + icache_ready: next state RUN; if kill=1, ifid_flush=1 that cycle and kill clears; if kill=0, ifid_flush=0 so the fetched word enters IF/ID.
REQ-014 icache_ready while in DMISS with imiss_pending SHALL clear imiss_pending and be remembered so that exit goes to RUN.
REQ-015 Outputs pc_hold … memwb_hold SHALL be combinational from state and inputs; state, flags, and stall_count SHALL be registered.
REQ-016 idex_bubble and idex_hold SHALL never be 1 together; idex_hold wins.
REQ-017 stall_count SHALL increment by 1 in every cycle where pc_hold or idex_hold is 1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-018 State encoding 3 SHALL be unreachable; if entered, the next state SHALL be RUN.

Reset
REQ-019 With reset=1 at a clk edge: state=RUN, kill=0, imiss_pending=0, stall_count=0.
REQ-020 During reset, all hold, flush, and bubble outputs SHALL be 0; reset mid-DMISS or mid-IMISS SHALL abort to RUN with no residual flags.

Verification
REQ-021 luh: ex_load=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_hold=ifid_hold=idex_bubble=1 for 1 cycle; stall_count=1.
REQ-022 ex_rd=0 load with id_rs1=0 -> no stall, all outputs 0.
REQ-023 dcache_miss at cycle 0, dcache_ready at cycle 4 -> all holds 1 in cycles 0–4, state=RUN at cycle 5, stall_count=5.
REQ-024 icache_miss, redirect at cycle 2, icache_ready at cycle 5 -> pc_hold=0 at cycle 2, ifid_flush=1 at cycle 5, state=RUN at cycle 6.
REQ-025 IMISS then dcache_miss at cycle 1, dcache_ready at cycle 3, no icache_ready -> state DMISS for cycles 2–3, then IMISS at cycle 4.
REQ-026 Reset asserted in DMISS -> state=RUN, stall_count=0, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Purpose: groups the pipeline-side signals of the hazard controller into one
// bundle. The master modport is the pipeline (drives hazard inputs, receives
// stall/flush controls); the slave modport is the hazard controller itself.
// Signals:
//   id_reg_rs1/id_reg_rs2 : source register indices of the instruction in ID
//   ex_reg_rd             : destination index of the instruction in EX
//   ex_load_word_memory   : EX instruction is a load
//   ex_redirect           : taken branch/jump resolved in EX
//   icache_miss/ready     : instruction cache miss / refill complete
//   dcache_miss/ready     : data cache miss (MEM) / refill complete
//   pc_hold .. memwb_hold : per-stage hold, flush and bubble controls
//   state                 : controller FSM state (0 RUN, 1 IMISS, 2 DMISS)
//   stall_count           : saturating stall-cycle counter
interface pipeline_hazard_controller_if;
  logic [4:0]  id_reg_rs1;
  logic [4:0]  id_reg_rs2;
  logic [4:0]  ex_reg_rd;
  logic        ex_load_word_memory;
  logic        ex_redirect;
  logic        icache_miss;
  logic        icache_ready;
  logic        dcache_miss;
  logic        dcache_ready;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        idex_hold;
  logic        exmem_hold;
  logic        memwb_hold;
  logic [1:0]  state;
  logic [31:0] stall_count;

  modport master (
    output id_reg_rs1, id_reg_rs2, ex_reg_rd, ex_load_word_memory, ex_redirect,
    output icache_miss, icache_ready, dcache_miss, dcache_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold,
    input  exmem_hold, memwb_hold, state, stall_count
  );

  modport slave (
    input  id_reg_rs1, id_reg_rs2, ex_reg_rd, ex_load_word_memory, ex_redirect,
    input  icache_miss, icache_ready, dcache_miss, dcache_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_hold,
    output exmem_hold, memwb_hold, state, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: hazard/stall controller for a 5-stage in-order pipeline. Resolves
// load-use hazards, EX redirects, and instruction/data cache misses into
// per-stage hold/flush/bubble controls, and counts stall cycles.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : pipeline_hazard_controller_if.slave (hazard inputs, stage
//           controls, FSM state, stall counter)
// Stage controls are combinational from state and inputs; state, the
// kill / imiss_pending flags and stall_count are registered.
module pipeline_hazard_controller (
  input  logic                           clk,
  input  logic                           reset,
  pipeline_hazard_controller_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IMISS   = 2'd1,
    ST_DMISS   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_kill;
  logic        w_kill_next;
  logic        r_imiss_pending;
  logic        w_imiss_pending_next;
  logic [31:0] r_stall_count;

  logic w_luh;
  logic w_pc_hold;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_bubble_raw;
  logic w_idex_hold;
  logic w_exmem_hold;
  logic w_memwb_hold;

  // Load-use: a load in EX writes a register the ID instruction reads.
  // x0 never carries a real dependency.
  assign w_luh = bus.ex_load_word_memory && (bus.ex_reg_rd != 5'd0) &&
                 ((bus.ex_reg_rd == bus.id_reg_rs1) ||
                  (bus.ex_reg_rd == bus.id_reg_rs2));

  // State / flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_kill          <= 1'b0;
      r_imiss_pending <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_kill          <= w_kill_next;
      r_imiss_pending <= w_imiss_pending_next;
    end
  end

  // Next-state and stage-control decode
  always_comb begin
    w_state_next         = r_state;
    w_kill_next          = r_kill;
    w_imiss_pending_next = r_imiss_pending;
    w_pc_hold            = 1'b0;
    w_ifid_hold          = 1'b0;
    w_ifid_flush         = 1'b0;
    w_bubble_raw         = 1'b0;
    w_idex_hold          = 1'b0;
    w_exmem_hold         = 1'b0;
    w_memwb_hold         = 1'b0;

    // Reset forces every control low regardless of state or inputs.
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (bus.dcache_miss) begin
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_idex_hold  = 1'b1;
            w_exmem_hold = 1'b1;
            w_memwb_hold = 1'b1;
            w_state_next = ST_DMISS;
          end else if (bus.ex_redirect) begin
            // Target loads into PC; wrong-path instructions in IF/ID and ID
            // are squashed. Any luh or icache miss belongs to the wrong path.
            w_ifid_flush = 1'b1;
            w_bubble_raw = 1'b1;
          end else if (w_luh) begin
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_bubble_raw = 1'b1;
          end else if (bus.icache_miss) begin
            w_pc_hold    = 1'b1;
            w_ifid_flush = 1'b1;
            w_kill_next  = 1'b0;
            w_state_next = ST_IMISS;
          end
        end

        ST_IMISS: begin
          if (bus.dcache_miss) begin
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_idex_hold  = 1'b1;
            w_exmem_hold = 1'b1;
            w_memwb_hold = 1'b1;
            w_state_next = ST_DMISS;
            // Remember the outstanding refill unless it completes right now.
            w_imiss_pending_next = !bus.icache_ready;
          end else begin
            // Back end keeps draining; front end waits on the refill. A
            // redirect still loads its target, and the refilled word is then
            // stale and must not enter IF/ID.
            w_pc_hold = !bus.ex_redirect;
            if (bus.icache_ready) begin
              w_ifid_flush = r_kill || bus.ex_redirect;
              w_kill_next  = 1'b0;
              w_state_next = ST_RUN;
            end else begin
              w_ifid_flush = 1'b1;
              if (bus.ex_redirect) begin
                w_kill_next = 1'b1;
              end
            end
          end
        end

        ST_DMISS: begin
          w_pc_hold    = 1'b1;
          w_ifid_hold  = 1'b1;
          w_idex_hold  = 1'b1;
          w_exmem_hold = 1'b1;
          w_memwb_hold = 1'b1;
          if (bus.icache_ready) begin
            w_imiss_pending_next = 1'b0;
          end
          if (bus.dcache_ready) begin
            if (r_imiss_pending && !bus.icache_ready) begin
              w_state_next = ST_IMISS;
            end else begin
              // Returning to RUN: no instruction refill is outstanding, so
              // drop any kill left over from the interrupted IMISS.
              w_state_next         = ST_RUN;
              w_kill_next          = 1'b0;
              w_imiss_pending_next = 1'b0;
            end
          end
        end

        default: begin
          w_state_next         = ST_RUN;
          w_kill_next          = 1'b0;
          w_imiss_pending_next = 1'b0;
        end
      endcase
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= 32'd0;
    end else if ((w_pc_hold || w_idex_hold) && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.pc_hold     = w_pc_hold;
  assign bus.ifid_hold   = w_ifid_hold;
  assign bus.ifid_flush  = w_ifid_flush;
  // A frozen ID/EX cannot simultaneously take a bubble.
  assign bus.idex_bubble = w_bubble_raw && !w_idex_hold;
  assign bus.idex_hold   = w_idex_hold;
  assign bus.exmem_hold  = w_exmem_hold;
  assign bus.memwb_hold  = w_memwb_hold;
  assign bus.state       = r_state;
  assign bus.stall_count = r_stall_count;

endmodule
